// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NREQ producers.
// Grants bounded bursts and throttles on FIFO occupancy so the FIFO never overflows.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         last,
  input  logic [NREQ*DW-1:0]      din,
  output logic [NREQ-1:0]         gnt,
  input  logic [4:0]              fifo_cnt,
  output logic                    fifo_wr,
  output logic [DW-1:0]           fifo_data,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    busy
);

  localparam int OW = $clog2(NREQ);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state;
  logic [OW-1:0] last_owner;
  logic [OW-1:0] pick;
  logic [OW-1:0] idx;
  logic          found;
  logic [4:0]    beat_cnt;
  logic [4:0]    cnt_eff;
  logic          full_eff;
  logic          accept;
  logic [DW-1:0] din_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign din_arr[i] = din[i*DW +: DW];
  end

  // A write already registered lands at the next edge, so count it as occupied.
  assign cnt_eff  = fifo_cnt + {4'b0, fifo_wr};
  assign full_eff = cnt_eff >= 5'(DEPTH);
  assign accept   = (state == BURST) && req[owner] && !full_eff;
  assign busy     = (state == BURST);

  always_comb begin
    gnt = '0;
    if (state == BURST && !full_eff)
      gnt[owner] = 1'b1;
  end

  // Scan upward from the producer after the previous owner, wrapping.
  always_comb begin
    pick  = last_owner;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = OW'((int'(last_owner) + k) % NREQ);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OW'(NREQ - 1);
      beat_cnt   <= '0;
      fifo_wr    <= 1'b0;
      fifo_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          fifo_wr <= 1'b0;
          if (|req) begin
            owner    <= pick;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          fifo_wr <= accept;
          if (accept) begin
            fifo_data <= din_arr[owner];
            beat_cnt  <= beat_cnt + 5'd1;
            if (last[owner] || (beat_cnt + 5'd1 == 5'(MAX_BURST))) begin
              state      <= IDLE;
              last_owner <= owner;
            end
          end else if (!req[owner]) begin
            state      <= IDLE;
            last_owner <= owner;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
